// File: rtl/ram_sing_sync_master.sv
// Single-port sync-read RAM controller: host valid/ready access plus a march self-test (write all, read back, count mismatches).
// Host writes 1/cycle, read response 1 cycle after accept (no backpressure); self-test takes 2*DEPTH+1 cycles.
module ram_sing_sync_master #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              bist_start,
  input  logic [WIDTH-1:0]  bist_pattern,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [ADDR_W:0]   bist_err_cnt,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  input  logic [WIDTH-1:0]  ram_dout
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, RD_WAIT, T_WR, T_RD, T_LAST} state_t;

  state_t            state;
  logic [ADDR_W:0]   idx;
  logic [WIDTH-1:0]  pat;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] cmp_addr;
  logic              cmp_vld;

  logic [ADDR_W-1:0] idx_a;
  logic              idx_last;
  logic              host_acc;
  logic              chk_now;
  logic              mism;
  logic [WIDTH-1:0]  exp_dat;

  assign idx_a     = idx[ADDR_W-1:0];
  assign idx_last  = (idx == (ADDR_W+1)'(DEPTH - 1));
  assign req_ready = !rst && (state == IDLE) && !bist_start;
  assign host_acc  = req_ready && req_valid;

  // Read-back compare runs one address behind the read issue; ram_dout is
  // only looked at when the previous edge was a read.
  assign exp_dat = pat ^ WIDTH'(cmp_addr);
  assign chk_now = cmp_vld && ((state == T_RD) || (state == T_LAST));
  assign mism    = chk_now && (ram_dout != exp_dat);

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (host_acc) begin
            ram_we   = req_we;
            ram_addr = req_addr;
            ram_din  = req_we ? req_wdata : '0;
          end
        end
        RD_WAIT: ram_addr = rd_addr;
        T_WR: begin
          ram_we   = 1'b1;
          ram_addr = idx_a;
          ram_din  = pat ^ WIDTH'(idx_a);
        end
        T_RD:    ram_addr = idx_a;
        default: ram_addr = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      pat            <= '0;
      rd_addr        <= '0;
      cmp_addr       <= '0;
      cmp_vld        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_addr       <= '0;
      bist_busy      <= 1'b0;
      bist_done      <= 1'b0;
      bist_pass      <= 1'b0;
      bist_err_cnt   <= '0;
      bist_fail_addr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      bist_done <= 1'b0;

      if (mism) begin
        if (bist_err_cnt == '0)
          bist_fail_addr <= cmp_addr;
        bist_err_cnt <= bist_err_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bist_start) begin
            state          <= T_WR;
            idx            <= '0;
            pat            <= bist_pattern;
            cmp_vld        <= 1'b0;
            bist_busy      <= 1'b1;
            bist_pass      <= 1'b0;
            bist_err_cnt   <= '0;
            bist_fail_addr <= '0;
          end else if (host_acc && !req_we) begin
            rd_addr <= req_addr;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= ram_dout;
          rsp_addr  <= rd_addr;
          state     <= IDLE;
        end
        T_WR: begin
          if (idx_last) begin
            idx   <= '0;
            state <= T_RD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        T_RD: begin
          cmp_addr <= idx_a;
          cmp_vld  <= 1'b1;
          if (idx_last)
            state <= T_LAST;
          else
            idx <= idx + 1'b1;
        end
        T_LAST: begin
          // Final verdict folds in the compare happening on this same edge.
          bist_pass <= (bist_err_cnt == '0) && !mism;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
          cmp_vld   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
